// File: rtl/tx_scramble_encoder.sv
// Transmit scrambler plus rate-1/2 K=7 convolutional encoder (g0=133o, g1=171o).
// SIGNAL bits are encoded in the clear. DATA bits are scrambled, and tail bits are forced to zero.
module tx_scramble_encoder #(
  parameter int         SIGNAL_BITS  = 24,
  parameter logic [6:0] DEFAULT_SEED = 7'b1011101
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] seed,
  input  logic       bit_in,
  input  logic       bit_in_valid,
  input  logic       tail_in,
  input  logic       last_in,
  output logic       A_out,
  output logic       B_out,
  output logic       AB_out_valid,
  output logic       busy,
  output logic [1:0] state_dbg_o
);

  localparam int CNT_W = (SIGNAL_BITS > 1) ? $clog2(SIGNAL_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIGNAL_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SIGNAL = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t           state_q;
  logic [6:0]       s_q;    // s_q[6] is s7, s_q[0] is s1
  logic [5:0]       d_q;    // d_q[0] is d1 (most recent), d_q[5] is d6
  logic [CNT_W-1:0] cnt_q;
  logic             a_q;
  logic             b_q;
  logic             valid_q;
  logic             busy_q;

  logic scr_fb;
  logic enc_x;
  logic enc_a;
  logic enc_b;

  always_comb begin
    scr_fb = s_q[6] ^ s_q[3];
    enc_x  = 1'b0;
    case (state_q)
      SIGNAL:  enc_x = bit_in;
      DATA:    enc_x = tail_in ? 1'b0 : (bit_in ^ scr_fb);
      default: enc_x = 1'b0;
    endcase
    enc_a = enc_x ^ d_q[1] ^ d_q[2] ^ d_q[4] ^ d_q[5];
    enc_b = enc_x ^ d_q[0] ^ d_q[1] ^ d_q[2] ^ d_q[5];
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= (seed == 7'd0) ? DEFAULT_SEED : seed;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SIGNAL;
          end
        end
        SIGNAL: begin
          if (bit_in_valid) begin
            a_q     <= enc_a;
            b_q     <= enc_b;
            valid_q <= 1'b1;
            d_q     <= {d_q[4:0], enc_x};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_in_valid) begin
            a_q     <= enc_a;
            b_q     <= enc_b;
            valid_q <= 1'b1;
            d_q     <= {d_q[4:0], enc_x};
            s_q     <= {s_q[5:0], scr_fb};
            if (last_in) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A_out        = a_q;
  assign B_out        = b_q;
  assign AB_out_valid = valid_q;
  assign busy         = busy_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_tx_scramble_encoder.sv
// Bench for tx_scramble_encoder: a reference model pushes the expected A/B pairs into a queue.
// A negedge monitor pops that queue and compares whenever AB_out_valid is high.
module tb_tx_scramble_encoder;

  logic       Clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] seed;
  logic       bit_in;
  logic       bit_in_valid;
  logic       tail_in;
  logic       last_in;
  logic       A_out;
  logic       B_out;
  logic       AB_out_valid;
  logic       busy;
  logic [1:0] state_dbg_o;

  always #5 Clk = ~Clk;

  tx_scramble_encoder dut (
    .Clk          (Clk),
    .reset        (reset),
    .start        (start),
    .seed         (seed),
    .bit_in       (bit_in),
    .bit_in_valid (bit_in_valid),
    .tail_in      (tail_in),
    .last_in      (last_in),
    .A_out        (A_out),
    .B_out        (B_out),
    .AB_out_valid (AB_out_valid),
    .busy         (busy),
    .state_dbg_o  (state_dbg_o)
  );

  logic [1:0] exp_q[$];
  logic [1:0] obs_log[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_valid  = 0;

  // Reference model state
  int         m_state = 0;   // 0 idle, 1 signal, 2 data
  int         m_cnt   = 0;
  logic [6:0] m_scr   = '0;  // bit 6 is s7
  logic [5:0] m_past  = '0;  // bit 5 is d1, bit 0 is d6
  logic       m_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge Clk) begin
    if (reset === 1'b0 && AB_out_valid === 1'b1) begin
      obs_log.push_back({A_out, B_out});
      n_valid++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pair: got %b%b expected no pair", A_out, B_out);
      end else begin
        check("pair", {30'd0, A_out, B_out}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cycle(input logic st, input logic [6:0] sd, input logic v,
                       input logic b, input logic t, input logic l);
    logic       x;
    logic       fb;
    logic [6:0] w;
    start = st; seed = sd; bit_in_valid = v; bit_in = b; tail_in = t; last_in = l;
    if (m_state == 0) begin
      if (st) begin
        m_scr   = (sd == 7'd0) ? 7'b1011101 : sd;
        m_past  = '0;
        m_cnt   = 0;
        m_busy  = 1'b1;
        m_state = 1;
      end
    end else if (v) begin
      if (m_state == 1) begin
        x = b;
        m_cnt++;
        if (m_cnt == 24) m_state = 2;
      end else begin
        fb    = m_scr[6] ^ m_scr[3];
        m_scr = {m_scr[5:0], fb};
        x     = t ? 1'b0 : (b ^ fb);
        if (l) begin
          m_state = 0;
          m_busy  = 1'b0;
        end
      end
      w = {x, m_past};
      exp_q.push_back({^(w & 7'o133), ^(w & 7'o171)});
      m_past = w[6:1];
    end
    @(posedge Clk);
    #1;
    start = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0; tail_in = 1'b0; last_in = 1'b0;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic run_frame(input logic [6:0] sd, input logic [23:0] sig, input int ndata,
                           input logic [63:0] dat, input logic [63:0] tl);
    cycle(1'b1, sd, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 7'd0, 1'b1, sig[i], 1'b0, 1'b0);
    for (int j = 0; j < ndata; j++)
      cycle(1'b0, 7'd0, 1'b1, dat[j], tl[j], (j == ndata - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         base;
    int         base3;
    int         vcnt;
    logic [6:0] imp_a;
    logic [6:0] imp_b;
    logic [1:0] t1_pairs [8];
    logic [63:0] tail_mask;

    reset = 1'b1; start = 1'b0; seed = '0; bit_in = 1'b0;
    bit_in_valid = 1'b0; tail_in = 1'b0; last_in = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_A", {31'd0, A_out}, 32'd0);
    check("rst_B", {31'd0, B_out}, 32'd0);
    check("rst_valid", {31'd0, AB_out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg_o}, 32'd0);
    reset = 1'b0;
    idle(2);

    // All-zero frame with seed 7F: DATA encodes the raw scrambler sequence
    base = obs_log.size();
    vcnt = n_valid;
    run_frame(7'h7F, 24'd0, 48, 64'd0, 64'd0);
    idle(2);
    check("t1_valid_count", n_valid - vcnt, 32'd72);
    for (int i = 0; i < 24; i++)
      check("t1_signal_zero", {30'd0, obs_log[base + i]}, 32'd0);
    // x = 0,0,0,0,1,1,1,0 gives {A,B} = 00,00,00,00,11,10,01,01
    t1_pairs = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 8; i++)
      check("t1_data_head", {30'd0, obs_log[base + 24 + i]}, {30'd0, t1_pairs[i]});

    // Impulse in SIGNAL bit 0
    base  = obs_log.size();
    imp_a = 7'b1011011;
    imp_b = 7'b1111001;
    run_frame(7'h7F, 24'h000001, 8, 64'd0, 64'd0);
    idle(2);
    for (int i = 0; i < 24; i++) begin
      check("imp_A", {31'd0, obs_log[base + i][1]}, (i < 7) ? {31'd0, imp_a[6 - i]} : 32'd0);
      check("imp_B", {31'd0, obs_log[base + i][0]}, (i < 7) ? {31'd0, imp_b[6 - i]} : 32'd0);
    end

    // All-ones DATA, final six bits flagged as tail
    tail_mask = 64'h3F << 24;
    base3 = obs_log.size();
    run_frame(7'h35, 24'h03C3A5, 30, {64{1'b1}}, tail_mask);
    idle(2);

    // Zero seed selects the default seed
    run_frame(7'd0, 24'h03C3A5, 40, 64'h000000DEADBEEF12, 64'd0);
    idle(2);

    // Bits in IDLE are ignored, start with valid in IDLE, start mid-DATA is ignored
    vcnt = n_valid;
    cycle(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 7'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 7'd0, 1'b1, i[0], 1'b0, 1'b0);
    for (int j = 0; j < 12; j++)
      cycle((j == 4), 7'h11, 1'b1, j[1], 1'b0, (j == 11));
    check("t5_state_idle", {30'd0, state_dbg_o}, 32'd0);
    idle(2);
    check("t5_valid_count", n_valid - vcnt, 32'd36);

    // Asynchronous reset mid-DATA, then rerun the tail frame
    cycle(1'b1, 7'h35, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) cycle(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_A", {31'd0, A_out}, 32'd0);
    check("arst_B", {31'd0, B_out}, 32'd0);
    check("arst_valid", {31'd0, AB_out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_queue", exp_q.size(), 32'd0);
    m_state = 0; m_busy = 1'b0; m_cnt = 0; m_past = '0; m_scr = '0;
    @(posedge Clk);
    #1;
    reset = 1'b0;
    idle(1);
    base = obs_log.size();
    run_frame(7'h35, 24'h03C3A5, 30, {64{1'b1}}, tail_mask);
    idle(2);
    for (int i = 0; i < 54; i++)
      check("rerun_match", {30'd0, obs_log[base + i]}, {30'd0, obs_log[base3 + i]});

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_scramble_encoder.md
# tx_scramble_encoder

Transmit-path stage that scrambles and rate-1/2 convolutionally encodes the serial frame bit stream (802.11a style, K=7, g0=133o, g1=171o). It drives the coded A/B bit-pair stream consumed directly by `data_interleaver`. The SIGNAL field is encoded unscrambled; DATA bits are scrambled, with flagged tail positions forced to zero. Output is one A/B pair per accepted input bit.

## Interface
- `SIGNAL_BITS`, default 24: number of SIGNAL-field input bits per frame.
- `DEFAULT_SEED`, default 7'b1011101: scrambler seed substituted when `seed` is zero.
- `Clk` input, 1 bit: single clock; all state on rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: one-cycle pulse that begins a frame; honoured only in IDLE.
- `seed` input, 7 bits: scrambler initial state, sampled on accepted `start`.
- `bit_in` input, 1 bit: serial frame bit, SIGNAL first, then SERVICE/PSDU/tail/pad.
- `bit_in_valid` input, 1 bit: qualifies `bit_in`, `tail_in` and `last_in`.
- `tail_in` input, 1 bit: DATA only; the scrambled bit is replaced by 0.
- `last_in` input, 1 bit: DATA only; marks the final bit of the frame.
- `A_out` output, 1 bit: coded bit from g0.
- `B_out` output, 1 bit: coded bit from g1.
- `AB_out_valid` output, 1 bit: qualifies `A_out`/`B_out`; one-cycle pulse per pair.
- `busy` output, 1 bit: high from the cycle after accepted `start` until the cycle after the `last_in` bit is accepted.

## Operation
- States: IDLE, SIGNAL, DATA.
- IDLE: `start` loads scrambler state `s[7:1]` = `seed`, or `DEFAULT_SEED` if `seed`==0. It clears encoder delay line `d[6:1]`, clears SIGNAL counter `cnt`, sets `busy`, and goes to SIGNAL. Valid bits in IDLE are ignored and produce no output.
- SIGNAL: each valid bit is encoded unscrambled and `cnt` increments. On the `SIGNAL_BITS`-th bit (cnt==23), go to DATA. `tail_in` and `last_in` are ignored in this state.
- Scrambler does not advance during SIGNAL.
- DATA: for each valid bit:
  - `fb` = s7 ^ s4; shift `s <= {s[6:1], fb}`.
  - Encoder input `x` = `tail_in` ? 0 : (`bit_in` ^ fb).
  - If `last_in`, go to IDLE and clear `busy` at that edge.
- Encoder, per valid bit in SIGNAL/DATA:
  - A = x^d2^d3^d5^d6.
  - B = x^d1^d2^d3^d6.
  - Then `d <= {d[5:1], x}`, so d1 is the most recent previous bit.
- Encoder delay line is not cleared between SIGNAL and DATA. It is already zero because SIGNAL carries six zero tail bits.
- No backpressure: the downstream stage accepts every valid pair.
- `start` while `busy`: ignored, seed not reloaded.
- `reset` asserted mid-frame: immediate return to IDLE; scrambler and encoder state are discarded. The downstream stage is reset by the same signal.

## Timing
- Reset values: `A_out`=0, `B_out`=0, `AB_out_valid`=0, `busy`=0, state IDLE, `s`=0, `d`=0, `cnt`=0.
- Latency: a bit accepted at edge N appears on `A_out`/`B_out` with `AB_out_valid`=1 after edge N, i.e. one registered stage.
- `AB_out_valid` is 0 on any cycle following an edge with no accepted bit. `A_out`/`B_out` hold their last value when not valid.
- Back-to-back valid inputs give back-to-back valid outputs; the sustained rate is one pair per clock.
- `start` and `bit_in_valid` in the same IDLE cycle: `start` is accepted and the bit is ignored.
- The first SIGNAL bit may arrive the cycle after `start`.
- SIGNAL→DATA is seamless: the 25th valid bit is processed as DATA with no gap.
- `last_in` on a bit with `tail_in`=1 is legal; both apply.

## Test plan
- All-zero SIGNAL (24 bits) and 48 zero DATA bits with `seed`=7'h7F → first 24 pairs A=B=0. DATA A/B streams equal encoding of scrambler sequence 0000111011110010…; 72 valid pulses total.
- Impulse: SIGNAL bit0=1, rest 0 → A over pairs 0..6 = 1,0,1,1,0,1,1 and B = 1,1,1,1,0,0,1; thereafter 0.
- DATA bits all 1 with `tail_in`=1 on six bits → those six encoder inputs are 0 regardless of scrambler. Output matches the golden model.
- `seed`=0 → scrambler runs from 7'b1011101. Output matches the golden model with that seed.
- `start` pulsed mid-DATA, and valid bits sent in IDLE → no state change and no extra `AB_out_valid`. `busy` drops exactly one cycle after the `last_in` bit is accepted.
- `reset` asserted mid-DATA → all outputs 0 asynchronously. A new frame after release encodes identically to a fresh run.
